// File: rtl/sparrow_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide over unsigned magnitudes, sign fix-up applied when leaving CALC.
module sparrow_muldiv #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy,
    output logic [1:0]      dbg_state
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready
    // && !flush; a response transfers where resp_valid && resp_ready. Both sides
    // hold their payload stable while valid is high and the partner is not ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]     opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;       // product / quotient sign
    logic                sa_q, sa_d;         // remainder sign
    logic                dz_q, dz_d;         // divide-by-zero seen at acceptance
    logic [XLEN-1:0]     result_q, result_d;

    // Request decode: signedness, magnitudes and special divide detection.
    logic            in_sa, in_sb, in_dz, in_ovf, in_special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    // Iteration datapath.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_step, div_step, acc_step, prod;
    logic [XLEN-1:0]   quot, rem, fixed_res;

    // Decode the incoming request into magnitudes and the special-case result.
    always_comb begin
        in_sa       = (req_op != 3'd3) && (req_op != 3'd5) && (req_op != 3'd7) && req_rs1[XLEN-1];
        in_sb       = ((req_op == 3'd0) || (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6))
                      && req_rs2[XLEN-1];
        a_mag       = in_sa ? (~req_rs1 + 1'b1) : req_rs1;
        b_mag       = in_sb ? (~req_rs2 + 1'b1) : req_rs2;
        in_dz       = (req_rs2 == '0);
        in_ovf      = !req_op[0] && (req_rs1 == MIN_INT) && (req_rs2 == ALL_ONES);
        in_special  = req_op[2] && (in_dz || in_ovf);
        special_res = req_op[1] ? (in_dz ? req_rs1 : '0) : (in_dz ? ALL_ONES : req_rs1);
    end

    // One radix-2 step for the latched op plus the signed fix-up of its result.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[XLEN]) begin
            div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        acc_step = op_q[2] ? div_step : mul_step;
        prod     = neg_q ? (~acc_step + 1'b1) : acc_step;
        quot     = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        if (!op_q[2]) begin
            fixed_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            fixed_res = sa_q ? (~rem + 1'b1) : rem;
        end else begin
            fixed_res = dz_q ? ALL_ONES : (neg_q ? (~quot + 1'b1) : quot);
        end
    end

    // Next-state logic: accept in IDLE, iterate in CALC, hold result in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        dz_d     = dz_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    op_d  = req_op;
                    sa_d  = in_sa;
                    neg_d = in_sa ^ in_sb;
                    dz_d  = in_dz;
                    cnt_d = '0;
                    if (req_op[2]) begin
                        opnd_d = b_mag;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                    end
                    if (FAST_SPECIAL && in_special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    result_d = fixed_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush abandons whatever is in flight, including an unconsumed result.
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q == S_CALC) || (state_q == S_DONE);
    assign resp_result = result_q;
    assign dbg_state   = state_q;

endmodule
